ring_seq: RTL and testbench

Parametrised multimode circular shift register that generalises the fixed 8-bit ring counter. It supports ring and Johnson (twisted-ring) rotation in either direction, parallel load, hold, and an internal step prescaler. Status pulses report each step, full-period wrap and one-hot corruption. It drives phase/digit-select patterns such as display multiplexing and stepper sequencing, and can be stepped slowly from the fast system clock.

---
 rtl/ring_seq.sv | 143 ++++++++++++++
 tb/tb_ring_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_seq.sv
// Multimode circular shift register: ring/Johnson rotation in either direction,
// parallel load, hold, step prescaler, and registered step/wrap/error pulses.
module ring_seq #(
   parameter int             N       = 8,
   parameter int             DIV     = 1,
   parameter logic [N-1:0]   SEED    = N'(1),
   parameter bit             AUTOFIX = 1'b1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic          dir,
   input  logic [1:0]    mode,
   input  logic [N-1:0]  d,
   output logic [N-1:0]  q,
   output logic          tick,
   output logic          wrap,
   output logic          err
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW = $clog2(2 * N);

   localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [PW-1:0] POS_ONE  = PW'(1);
   localparam logic [PW-1:0] PER_RING = PW'(N - 1);
   localparam logic [PW-1:0] PER_JOHN = PW'(2 * N - 1);

   typedef enum logic [1:0] {
      MODE_RING = 2'b00,
      MODE_JOHN = 2'b01,
      MODE_LOAD = 2'b10,
      MODE_HOLD = 2'b11
   } mode_t;

   logic [N-1:0]  q_reg, q_next;
   logic [DW-1:0] div_cnt_reg, div_cnt_next;
   logic [PW-1:0] pos_reg, pos_next;
   logic          last_mode_reg, last_mode_next;
   logic          tick_reg, tick_next;
   logic          wrap_reg, wrap_next;
   logic          err_reg, err_next;

   logic [N-1:0]  rot_lsb, rot_msb;
   logic          fb_lsb, fb_msb;
   logic          john;
   logic [PW-1:0] pos_last;
   logic          bad_onehot;
   mode_t         mode_sel;

   assign mode_sel = mode_t'(mode);
   assign john     = mode[0];
   assign pos_last = john ? PER_JOHN : PER_RING;

   // Johnson feeds back the inverted outgoing bit; ring feeds it back as-is.
   assign fb_lsb = john ? ~q_reg[0]   : q_reg[0];
   assign fb_msb = john ? ~q_reg[N-1] : q_reg[N-1];

   generate
      for (genvar gi = 0; gi < N - 1; gi++) begin : g_shift
         assign rot_lsb[gi]   = q_reg[gi+1];
         assign rot_msb[gi+1] = q_reg[gi];
      end
   endgenerate
   assign rot_lsb[N-1] = fb_lsb;
   assign rot_msb[0]   = fb_msb;

   assign bad_onehot = ($countones(q_reg) != 1);

   always_comb begin
      q_next         = q_reg;
      div_cnt_next   = div_cnt_reg;
      pos_next       = pos_reg;
      last_mode_next = last_mode_reg;
      tick_next      = 1'b0;
      wrap_next      = 1'b0;
      err_next       = 1'b0;
      case (mode_sel)
         MODE_LOAD: begin
            q_next       = d;
            div_cnt_next = '0;
            pos_next     = '0;
         end
         MODE_HOLD: begin
         end
         default: begin
            if (john != last_mode_reg) begin
               // Switching rotate flavour restarts the period without stepping.
               div_cnt_next   = '0;
               pos_next       = '0;
               last_mode_next = john;
            end else if (en) begin
               if (div_cnt_reg == DIV_MAX) begin
                  div_cnt_next = '0;
                  tick_next    = 1'b1;
                  if (AUTOFIX && !john && bad_onehot) begin
                     q_next   = SEED;
                     pos_next = '0;
                     err_next = 1'b1;
                  end else begin
                     q_next = dir ? rot_msb : rot_lsb;
                     if (pos_reg == pos_last) begin
                        pos_next  = '0;
                        wrap_next = 1'b1;
                     end else begin
                        pos_next = pos_reg + POS_ONE;
                     end
                  end
               end else begin
                  div_cnt_next = div_cnt_reg + DIV_ONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q_reg         <= SEED;
         div_cnt_reg   <= '0;
         pos_reg       <= '0;
         last_mode_reg <= 1'b0;
         tick_reg      <= 1'b0;
         wrap_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         q_reg         <= q_next;
         div_cnt_reg   <= div_cnt_next;
         pos_reg       <= pos_next;
         last_mode_reg <= last_mode_next;
         tick_reg      <= tick_next;
         wrap_reg      <= wrap_next;
         err_reg       <= err_next;
      end
   end

   assign q    = q_reg;
   assign tick = tick_reg;
   assign wrap = wrap_reg;
   assign err  = err_reg;

endmodule

// File: tb/tb_ring_seq.sv
// Directed bench for ring_seq: a DIV=1 and a DIV=3 instance share one set of inputs;
// a vector table covers basic rotation, hand sequences cover prescale and corner cases.
module tb_ring_seq;

   logic       clk = 1'b0;
   logic       clr, en, dir;
   logic [1:0] mode;
   logic [7:0] d;
   logic [7:0] q1, q3;
   logic       tick1, wrap1, err1, tick3, wrap3, err3;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   ring_seq #(.N(8), .DIV(1), .SEED(8'h01), .AUTOFIX(1'b1)) u1 (
      .clk(clk), .clr(clr), .en(en), .dir(dir), .mode(mode), .d(d),
      .q(q1), .tick(tick1), .wrap(wrap1), .err(err1)
   );

   ring_seq #(.N(8), .DIV(3), .SEED(8'h01), .AUTOFIX(1'b1)) u3 (
      .clk(clk), .clr(clr), .en(en), .dir(dir), .mode(mode), .d(d),
      .q(q3), .tick(tick3), .wrap(wrap3), .err(err3)
   );

   typedef struct {
      logic       c, e, dr;
      logic [1:0] m;
      logic [7:0] dd;
      logic [7:0] eq;
      logic       et, ew, ee;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic c, input logic e, input logic dr, input logic [1:0] m,
                       input logic [7:0] dd, input logic [7:0] eq,
                       input logic et, input logic ew, input logic ee);
      vec_t v;
      v.c = c; v.e = e; v.dr = dr; v.m = m; v.dd = dd;
      v.eq = eq; v.et = et; v.ew = ew; v.ee = ee;
      vecs.push_back(v);
   endtask

   task automatic step(input logic c, input logic e, input logic dr, input logic [1:0] m,
                       input logic [7:0] dd);
      clr = c; en = e; dir = dr; mode = m; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_q;
      clr = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b11; d = 8'h00;

      // Reset, ring toward LSB, hold, load 0, switch to Johnson toward MSB
      addv(1,0,0,2'b11,8'h00, 8'h01,0,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h80,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h40,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h20,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h10,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h08,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h04,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h02,1,0,0);
      addv(0,1,0,2'b00,8'h00, 8'h01,1,1,0);
      addv(0,1,0,2'b11,8'h00, 8'h01,0,0,0);
      addv(0,0,0,2'b00,8'h00, 8'h01,0,0,0);
      addv(0,1,0,2'b10,8'h00, 8'h00,0,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h00,0,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h01,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h03,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h07,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h0F,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h1F,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h3F,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h7F,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hFF,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hFE,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hFC,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hF8,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hF0,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hE0,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'hC0,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h80,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h00,1,1,0);
      // Direction change takes effect immediately
      addv(0,1,0,2'b01,8'h00, 8'h80,1,0,0);
      addv(0,1,1,2'b01,8'h00, 8'h00,1,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].c, vecs[i].e, vecs[i].dr, vecs[i].m, vecs[i].dd);
         $display("vec %0d: mode=%b dir=%b en=%b -> q=%h tick=%b wrap=%b err=%b",
                  i, vecs[i].m, vecs[i].dr, vecs[i].e, q1, tick1, wrap1, err1);
         chk($sformatf("vec%0d_q", i),    q1,    vecs[i].eq);
         chk($sformatf("vec%0d_tick", i), tick1, vecs[i].et);
         chk($sformatf("vec%0d_wrap", i), wrap1, vecs[i].ew);
         chk($sformatf("vec%0d_err", i),  err1,  vecs[i].ee);
      end

      // Prescaler DIV=3 with an en gap
      step(1,0,0,2'b11,8'h00);
      chk("div3_reset_q", q3, 8'h01);
      for (int i = 1; i <= 3; i++) begin
         step(0,1,0,2'b00,8'h00);
         chk($sformatf("div3_tick%0d", i), tick3, (i == 3));
      end
      chk("div3_first_q", q3, 8'h80);
      step(0,1,0,2'b00,8'h00);
      chk("div3_partial_tick", tick3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(0,0,0,2'b00,8'h00);
         chk($sformatf("div3_gap_q%0d", i), q3, 8'h80);
         chk($sformatf("div3_gap_tick%0d", i), tick3, 1'b0);
      end
      step(0,1,0,2'b00,8'h00);
      chk("div3_resume1_q", q3, 8'h80);
      chk("div3_resume1_tick", tick3, 1'b0);
      step(0,1,0,2'b00,8'h00);
      chk("div3_resume2_q", q3, 8'h40);
      chk("div3_resume2_tick", tick3, 1'b1);
      $display("div3 prescale sequence done: q=%h", q3);

      // Mid-period clear together with load
      step(1,0,0,2'b11,8'h00);
      for (int i = 0; i < 16; i++) step(0,1,0,2'b00,8'h00);
      chk("mid_q_before_clr", q3, 8'h08);
      step(1,1,0,2'b10,8'hAA);
      chk("clr_q", q3, 8'h01);
      chk("clr_tick", tick3, 1'b0);
      chk("clr_wrap", wrap3, 1'b0);
      chk("clr_err", err3, 1'b0);
      chk("clr_q_div1", q1, 8'h01);
      for (int i = 1; i <= 24; i++) begin
         step(0,1,0,2'b00,8'h00);
         chk($sformatf("restart_wrap%0d", i), wrap3, (i == 24));
         chk($sformatf("restart_tick%0d", i), tick3, (i % 3 == 0));
      end
      chk("restart_final_q", q3, 8'h01);
      $display("clear-restart sequence done: q=%h", q3);

      // Auto-fix in ring mode
      step(1,0,0,2'b11,8'h00);
      step(0,1,0,2'b10,8'h05);
      chk("fix_load_q", q1, 8'h05);
      step(0,1,0,2'b00,8'h00);
      chk("fix_q", q1, 8'h01);
      chk("fix_err", err1, 1'b1);
      chk("fix_tick", tick1, 1'b1);
      chk("fix_wrap", wrap1, 1'b0);
      exp_q = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         step(0,1,0,2'b00,8'h00);
         exp_q = {exp_q[0], exp_q[7:1]};
         chk($sformatf("postfix_q%0d", i), q1, exp_q);
         chk($sformatf("postfix_wrap%0d", i), wrap1, (i == 8));
         chk($sformatf("postfix_err%0d", i), err1, 1'b0);
      end

      // Johnson never auto-fixes
      step(0,1,0,2'b10,8'h05);
      step(0,1,0,2'b01,8'h00);
      chk("jnofix_switch_q", q1, 8'h05);
      chk("jnofix_switch_tick", tick1, 1'b0);
      step(0,1,0,2'b01,8'h00);
      chk("jnofix_q", q1, 8'h02);
      chk("jnofix_err", err1, 1'b0);
      chk("jnofix_tick", tick1, 1'b1);
      $display("auto-fix sequences done: q=%h", q1);

      // Ring to Johnson switch while running
      step(1,0,0,2'b11,8'h00);
      for (int i = 0; i < 3; i++) step(0,1,0,2'b00,8'h00);
      chk("sw_ring_q", q1, 8'h20);
      step(0,1,0,2'b01,8'h00);
      chk("sw_dead_q", q1, 8'h20);
      chk("sw_dead_tick", tick1, 1'b0);
      chk("sw_dead_wrap", wrap1, 1'b0);
      exp_q = 8'h20;
      for (int i = 1; i <= 16; i++) begin
         step(0,1,0,2'b01,8'h00);
         exp_q = {~exp_q[0], exp_q[7:1]};
         chk($sformatf("sw_john_q%0d", i), q1, exp_q);
         chk($sformatf("sw_john_tick%0d", i), tick1, 1'b1);
         chk($sformatf("sw_john_wrap%0d", i), wrap1, (i == 16));
      end
      $display("mode switch sequence done: q=%h", q1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
